// File: rtl/in_pkg.sv
// Shared types and constants for the input controller.
// Holds the transfer FSM state encoding and the default debounce length.
package in_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } state_t;

    localparam int unsigned DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer.
// Ports: clock, reset (sync, active high), raw (async in), level (debounced).
module debounce
    import in_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [15:0] LAST = 16'(CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic [15:0] count;

    // level flips once sync2 has disagreed with it for CYCLES samples
    // in a row; any sample that agrees restarts the run from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (count == LAST) begin
                    level <= sync2;
                    count <= '0;
                end else begin
                    count <= count + 16'd1;
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/input_ctrl.sv
// Switch/button input controller: hands a switch value to the CPU per IN request.
// Ports: clock, reset (sync, active high), sw, btn, inreq in; inval, inack,
// waiting, echo_val, echo_display out. Macro INPUT_ECHO_EN enables the echo regs.
module input_ctrl
    import in_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int          WIDTH           = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    input  logic             inreq,
    output logic [WIDTH-1:0] inval,
    output logic             inack,
    output logic             waiting,
    output logic [WIDTH-1:0] echo_val,
    output logic             echo_display
);

    state_t           state;
    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] hold;
    logic             btn_db;
    // Cleared after a transfer; set again once inreq is seen low, so a
    // request held high across DONE cannot start a second transfer.
    logic             armed;

    debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clock(clock),
        .reset(reset),
        .raw  (btn),
        .level(btn_db)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // WAIT_PRESS is only entered with btn_db low, so btn_db high there
    // marks its rising edge; likewise btn_db low in WAIT_RELEASE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            inval   <= '0;
            inack   <= 1'b0;
            waiting <= 1'b0;
            hold    <= '0;
            armed   <= 1'b1;
        end else begin
            inack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!inreq) begin
                        armed <= 1'b1;
                    end
                    if (inreq && armed && !btn_db) begin
                        state   <= WAIT_PRESS;
                        waiting <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (!inreq) begin
                        state   <= IDLE;
                        waiting <= 1'b0;
                    end else if (btn_db) begin
                        hold  <= sw_sync;
                        state <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!btn_db) begin
                        if (inreq) begin
                            state <= DONE;
                            inval <= hold;
                            inack <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            waiting <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    waiting <= 1'b0;
                    armed   <= ~inreq;
                end
                default: begin
                    state   <= IDLE;
                    waiting <= 1'b0;
                end
            endcase
        end
    end

`ifdef INPUT_ECHO_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            echo_val     <= '0;
            echo_display <= 1'b0;
        end else begin
            echo_val     <= sw_sync;
            echo_display <= waiting;
        end
    end
`else
    assign echo_val     = '0;
    assign echo_display = 1'b0;
`endif

endmodule

// File: doc/input_ctrl.md
INPUT_CTRL -- requirements
Module: input_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive stable samples required to accept a button level change (legal range 1..65535).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the data width of sw, inval and echo_val.
REQ-003 Port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port sw, input, WIDTH, raw DIP-switch value, asynchronous to clock.
REQ-006 Port btn, input, 1, raw enter push-button, asynchronous to clock, high when pressed.
REQ-007 Port inreq, input, 1, level request from the CPU: an IN instruction is waiting for data.
REQ-008 Port inval, output, WIDTH, last accepted input value; held between transfers.
REQ-009 Port inack, output, 1, single-cycle pulse; inval is valid in that cycle and afterwards.
REQ-010 Port waiting, output, 1, high whenever the FSM is not in IDLE (drives the "enter value" indicator).
REQ-011 Port echo_val, output, WIDTH, live synchronised switch value for the display block.
REQ-012 Port echo_display, output, 1, display-enable strobe for echo_val.

Function
REQ-013 sw and btn SHALL each pass through a 2-flop synchroniser before any use.
REQ-014 The debounced button level btn_db SHALL change only after the synchronised btn has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles; any glitch back restarts the count from 0.
REQ-015 With the raw btn stable, btn_db SHALL follow a raw edge after exactly DEBOUNCE_CYCLES+2 cycles.
REQ-016 The FSM states SHALL be IDLE, WAIT_PRESS, WAIT_RELEASE and DONE.
REQ-017 IDLE -> WAIT_PRESS when inreq=1 and btn_db=0; if btn_db=1, the FSM SHALL stay in IDLE until btn_db=0, so a held button never auto-accepts.
REQ-018 WAIT_PRESS -> WAIT_RELEASE on the btn_db rising edge, capturing the synchronised sw into a holding register in that same cycle.
REQ-019 WAIT_PRESS -> IDLE with no capture and no inack when inreq falls.
REQ-020 WAIT_RELEASE -> DONE on the btn_db falling edge if inreq=1, otherwise -> IDLE with no inack; a held button therefore blocks completion.
REQ-021 In DONE, inval SHALL load the holding register, inack SHALL be 1 for exactly that cycle, and the next state SHALL be IDLE.
REQ-022 Press-to-inack latency SHALL be the release-debounce delay plus 1 cycle; inval SHALL be visible in the same cycle as inack.
REQ-023 inval SHALL change only in DONE.
REQ-024 If inreq stays high through DONE, IDLE SHALL re-arm only after inreq is observed low for at least 1 cycle, so one request yields one transfer.

Reset
REQ-025 Reset SHALL force: FSM to IDLE, inval=0, inack=0, waiting=0, holding register=0, synchronisers=0, btn_db=0, debounce counter=0, echo_val=0, echo_display=0.
REQ-026 Reset asserted in any state SHALL abort the transfer with no inack, and reset SHALL take priority over every transition.

Configuration
REQ-027 The macro INPUT_ECHO_EN SHALL control the echo feature.
REQ-028 With INPUT_ECHO_EN defined: echo_val = synchronised sw, registered, and echo_display = waiting, registered, so the display shows the switches while input is pending.
REQ-029 With INPUT_ECHO_EN undefined: echo_val and echo_display SHALL be tied to 0, with no registers, and the port list SHALL be unchanged.

Structure
REQ-030 A shared package in_pkg SHALL hold the FSM state enum (2-bit) and the DEBOUNCE_CYCLES default constant.
REQ-031 The synchroniser and debounce logic SHALL be a sub-module named debounce, instantiated once for btn; sw SHALL use only the synchroniser.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset, then inreq=1, sw=16'h1234, clean btn press held 10 cycles then release -> one inack pulse 7 cycles after the raw release, with inval=16'h1234.
REQ-033 btn glitching high for 3 cycles in WAIT_PRESS -> no capture, state stays WAIT_PRESS, inval unchanged.
REQ-034 inreq dropped in WAIT_PRESS -> IDLE, no inack; inreq dropped in WAIT_RELEASE, then release -> IDLE, no inack, inval unchanged.
REQ-035 btn held before inreq rises -> FSM stays IDLE until release debounces, and no inack until a fresh press/release.
REQ-036 sw changed from 16'hAAAA to 16'h5555 while the button is held -> inval=16'hAAAA, the value at press.
REQ-037 reset pulsed in WAIT_RELEASE -> next cycle all outputs 0 and state IDLE; echo_display=1 only while waiting when INPUT_ECHO_EN is defined, and always 0 otherwise.
